decode_operand_stage: RTL and testbench
=======================================

# decode_operand_stage

Decode-side operand stage of the 5-stage RISC-V pipeline, between the IF/ID register and the execute stage. Drives the register file's read addresses, bypasses same-cycle writeback data the register file cannot yet return, generates immediates, detects load-use hazards, and owns the ID/EX pipeline register. Load-use hazards are resolved with a one-cycle bubble, EX back-pressure with a hold, and branch redirects with a flush.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- id_valid  in  1  IF/ID holds a valid instruction
- id_pc  in  32  PC of the IF/ID instruction
- id_instr  in  32  instruction word
- addr_rs1  out  5  register file read address; always id_instr[19:15], combinational
- addr_rs2  out  5  register file read address; always id_instr[24:20], combinational
- data_rs1  in  32  register file read data (combinational read)
- data_rs2  in  32  register file read data (combinational read)
- wb_write_enable  in  1  writeback writes the register file this cycle
- wb_addr_rd  in  5  writeback destination register
- wb_data_rd  in  32  writeback data
- ex_stall  in  1  EX cannot accept; hold the ID/EX register
- flush  in  1  branch/jump redirect; kill ID and ID/EX contents
- stall  out  1  hold PC and IF/ID; combinational
- ex_valid  out  1  ID/EX entry valid
- ex_pc  out  32  registered PC
- ex_instr  out  32  registered instruction
- ex_rs1_data  out  32  registered rs1 operand
- ex_rs2_data  out  32  registered rs2 operand
- ex_imm  out  32  registered sign-extended immediate
- ex_rd  out  5  registered destination; 0 if the instruction does not write
- ex_is_load  out  1  registered: opcode is 0000011

## Operation
- Opcode = id_instr[6:0].
- uses_rs1: all opcodes except LUI 0110111, AUIPC 0010111 and JAL 1101111.
- uses_rs2: R-type 0110011, STORE 0100011 and BRANCH 1100011 only.
- Destination: rd = id_instr[11:7] except for STORE/BRANCH, where rd = 0.
- Immediate, selected by opcode:
  - I-type (0010011, 0000011, 1100111, 1110011): sign-extend id_instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All other opcodes: 0.
  - All signed immediates sign-extend to 32 bits.
- WB bypass, per operand: if wb_write_enable && wb_addr_rd != 0 && wb_addr_rd == addr_rsN, the operand is wb_data_rd; otherwise it is data_rsN. Register x0 is never bypassed, so an x0 operand is always 0.
- Load-use hazard (lu) asserts when all of the following hold:
  - id_valid, ex_valid and ex_is_load;
  - ex_rd != 0;
  - (uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd).
- stall = !flush && (ex_stall || lu).
- ID/EX update priority, per posedge:
  1. reset: all ex_* outputs are 0.
  2. flush: ex_valid = 0; other fields don't-care (held).
  3. ex_stall: all fields hold.
  4. lu: ex_valid = 0 (bubble); the ID instruction stays in IF/ID because stall is high.
  5. Otherwise: capture ex_valid = id_valid, plus pc, instr, bypassed operands, imm, rd and is_load.
- Only the bubble case from lu is inserted; there is no multi-cycle interlock. MEM/WB-to-EX forwarding is the EX stage's responsibility.

## Timing
- Latency: an ID instruction appears on ex_* one cycle after the edge where it is captured.
- Reset values: ex_valid 0, ex_pc 0, ex_instr 0, ex_rs1_data 0, ex_rs2_data 0, ex_imm 0, ex_rd 0, ex_is_load 0.
- stall is combinational and is 0 whenever flush = 1.
- A load-use stall lasts exactly one cycle. The following cycle, the load has moved to MEM and ex_valid = 0, so lu deasserts.
- Operands are re-read every cycle during a stall. A register written by WB during a stall cycle is therefore seen, either through the register file or through the bypass.
- Simultaneous flush + ex_stall: flush wins; the entry is invalidated.
- Simultaneous flush + lu: flush wins and stall = 0.
- Reset mid-stall or mid-flush: the next cycle shows reset values. Reset is not gated by any other input.

## Test plan
- Reset asserted for 2 cycles, then released, with id_valid = 0: all ex_* = 0 and stall = 0.
- Bypass: ADD x3, x1, x2 with data_rs1 = 5 and WB writing x1 = 0x1234 in the same cycle. Expected: ex_rs1_data = 0x1234, ex_rs2_data = data_rs2. Repeat with wb_addr_rd = 0: no bypass.
- Load-use: LW x5 in EX, then ADD x6, x5, x7 in ID. Expected: stall = 1 for one cycle, a bubble (ex_valid = 0), then ADD captured. Repeat with LUI x5 in EX: no stall. Repeat with an x0 destination: no stall.
- Immediates, checked on ex_imm:
  - SW with offset −4 (instr 0xFE112E23): 0xFFFFFFFC.
  - BEQ with −8: 0xFFFFFFF8.
  - LUI 0x12345: 0x12345000.
  - JAL +2048: 0x00000800.
- Flush with ex_stall = 1 and a valid instruction in ID: next cycle ex_valid = 0, and stall = 0 during the flush cycle.
- ex_stall held for 3 cycles: ex_* holds its values and stall = 1 throughout. WB writes a source register during the hold; when ex_stall releases, the captured ID operand reflects the new value.

Source files
------------

// File: rtl/decode_operand_stage.sv
// Decode-side operand stage: register read addressing, writeback bypass, immediate
// generation, load-use detection and the ID/EX pipeline register.
module decode_operand_stage #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [31:0]     id_pc,
   input  logic [31:0]     id_instr,
   output logic [4:0]      addr_rs1,
   output logic [4:0]      addr_rs2,
   input  logic [XLEN-1:0] data_rs1,
   input  logic [XLEN-1:0] data_rs2,
   input  logic            wb_write_enable,
   input  logic [4:0]      wb_addr_rd,
   input  logic [XLEN-1:0] wb_data_rd,
   input  logic            ex_stall,
   input  logic            flush,
   output logic            stall,
   output logic            ex_valid,
   output logic [31:0]     ex_pc,
   output logic [31:0]     ex_instr,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd,
   output logic            ex_is_load
);

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_OPIMM  = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_OP     = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111,
      OP_SYSTEM = 7'b1110011
   } opcode_e;

   opcode_e          opcode;
   logic             uses_rs1;
   logic             uses_rs2;
   logic [4:0]       rd;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  rs1_op;
   logic [XLEN-1:0]  rs2_op;
   logic             lu;

   assign opcode   = opcode_e'(id_instr[6:0]);
   assign addr_rs1 = id_instr[19:15];
   assign addr_rs2 = id_instr[24:20];

   assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   assign uses_rs2 = (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
   assign rd       = (opcode == OP_STORE || opcode == OP_BRANCH) ? 5'd0 : id_instr[11:7];

   always_comb begin
      imm = '0;
      case (opcode)
         OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM:
            imm = {{20{id_instr[31]}}, id_instr[31:20]};
         OP_STORE:
            imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
         OP_BRANCH:
            imm = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
                   id_instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {id_instr[31:12], 12'b0};
         OP_JAL:
            imm = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20],
                   id_instr[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

   // The register file returns pre-write data in the writeback cycle; x0 is never bypassed.
   assign rs1_op = (wb_write_enable && wb_addr_rd != 5'd0 && wb_addr_rd == addr_rs1)
                   ? wb_data_rd : data_rs1;
   assign rs2_op = (wb_write_enable && wb_addr_rd != 5'd0 && wb_addr_rd == addr_rs2)
                   ? wb_data_rd : data_rs2;

   assign lu = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
               ((uses_rs1 && addr_rs1 == ex_rd) || (uses_rs2 && addr_rs2 == ex_rd));

   assign stall = !flush && (ex_stall || lu);

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_instr    <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_is_load  <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (ex_stall) begin
         ex_valid <= ex_valid;
      end else if (lu) begin
         ex_valid <= 1'b0;
      end else begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_instr    <= id_instr;
         ex_rs1_data <= rs1_op;
         ex_rs2_data <= rs2_op;
         ex_imm      <= imm;
         ex_rd       <= rd;
         ex_is_load  <= (opcode == OP_LOAD);
      end
   end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage: bypass, load-use bubble, immediates,
// flush/ex_stall priority and reset behaviour.
module tb_decode_operand_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [4:0]  addr_rs1;
   logic [4:0]  addr_rs2;
   logic [31:0] data_rs1;
   logic [31:0] data_rs2;
   logic        wb_write_enable;
   logic [4:0]  wb_addr_rd;
   logic [31:0] wb_data_rd;
   logic        ex_stall;
   logic        flush;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_instr;
   logic [31:0] ex_rs1_data;
   logic [31:0] ex_rs2_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic        ex_is_load;

   int unsigned errors = 0;
   int unsigned checks = 0;

   localparam logic [31:0] ADD_3_1_2 = 32'h002081B3;
   localparam logic [31:0] ADD_3_0_2 = 32'h002001B3;
   localparam logic [31:0] LW_5_1    = 32'h0000A283;
   localparam logic [31:0] LW_0_1    = 32'h0000A003;
   localparam logic [31:0] ADD_6_5_7 = 32'h00728333;
   localparam logic [31:0] ADD_6_0_7 = 32'h00700333;
   localparam logic [31:0] LUI_5     = 32'h123452B7;
   localparam logic [31:0] SW_M4     = 32'hFE112E23;
   localparam logic [31:0] BEQ_M8    = 32'hFE208CE3;
   localparam logic [31:0] JAL_2048  = 32'h001000EF;

   decode_operand_stage #(.XLEN(32)) dut (
      .clock(clock), .reset(reset),
      .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
      .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
      .data_rs1(data_rs1), .data_rs2(data_rs2),
      .wb_write_enable(wb_write_enable), .wb_addr_rd(wb_addr_rd), .wb_data_rd(wb_data_rd),
      .ex_stall(ex_stall), .flush(flush), .stall(stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_is_load(ex_is_load)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock edge, then let outputs settle before checking/driving.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] d1, input logic [31:0] d2);
      id_valid = v;
      id_pc    = pc;
      id_instr = ins;
      data_rs1 = d1;
      data_rs2 = d2;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; id_valid = 0; id_pc = 0; id_instr = 0; data_rs1 = 0; data_rs2 = 0;
      wb_write_enable = 0; wb_addr_rd = 0; wb_data_rd = 0; ex_stall = 0; flush = 0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst_valid", {31'b0, ex_valid}, 32'd0);
      check("rst_pc", ex_pc, 32'd0);
      check("rst_instr", ex_instr, 32'd0);
      check("rst_rs1", ex_rs1_data, 32'd0);
      check("rst_rs2", ex_rs2_data, 32'd0);
      check("rst_imm", ex_imm, 32'd0);
      check("rst_rd", {27'b0, ex_rd}, 32'd0);
      check("rst_load", {31'b0, ex_is_load}, 32'd0);
      check("rst_stall", {31'b0, stall}, 32'd0);
      tick();
      check("idle_valid", {31'b0, ex_valid}, 32'd0);

      // Bypass on rs1
      put(1, 32'h100, ADD_3_1_2, 32'd5, 32'h77);
      wb_write_enable = 1; wb_addr_rd = 5'd1; wb_data_rd = 32'h1234;
      #1;
      check("addr_rs1", {27'b0, addr_rs1}, 32'd1);
      check("addr_rs2", {27'b0, addr_rs2}, 32'd2);
      check("byp_stall", {31'b0, stall}, 32'd0);
      tick();
      check("byp_valid", {31'b0, ex_valid}, 32'd1);
      check("byp_pc", ex_pc, 32'h100);
      check("byp_instr", ex_instr, ADD_3_1_2);
      check("byp_rs1", ex_rs1_data, 32'h1234);
      check("byp_rs2", ex_rs2_data, 32'h77);
      check("byp_rd", {27'b0, ex_rd}, 32'd3);
      check("byp_imm", ex_imm, 32'd0);

      // Bypass on rs2
      put(1, 32'h104, ADD_3_1_2, 32'd5, 32'h77);
      wb_addr_rd = 5'd2; wb_data_rd = 32'hCAFE;
      tick();
      check("byp2_rs1", ex_rs1_data, 32'd5);
      check("byp2_rs2", ex_rs2_data, 32'hCAFE);

      // x0 is never bypassed
      put(1, 32'h108, ADD_3_0_2, 32'd0, 32'h77);
      wb_addr_rd = 5'd0; wb_data_rd = 32'h5555;
      tick();
      check("x0_rs1", ex_rs1_data, 32'd0);

      // Write enable low: no bypass
      put(1, 32'h10C, ADD_3_1_2, 32'd5, 32'h77);
      wb_write_enable = 0; wb_addr_rd = 5'd1; wb_data_rd = 32'h9999;
      tick();
      check("nowe_rs1", ex_rs1_data, 32'd5);
      wb_addr_rd = 0; wb_data_rd = 0;

      // Load-use: LW x5 then ADD x6,x5,x7
      put(1, 32'h200, LW_5_1, 32'd0, 32'd0);
      check("lw_stall_pre", {31'b0, stall}, 32'd0);
      tick();
      check("lw_is_load", {31'b0, ex_is_load}, 32'd1);
      check("lw_rd", {27'b0, ex_rd}, 32'd5);
      put(1, 32'h204, ADD_6_5_7, 32'hAA, 32'hBB);
      check("lu_stall", {31'b0, stall}, 32'd1);
      tick();
      check("lu_bubble", {31'b0, ex_valid}, 32'd0);
      check("lu_stall_end", {31'b0, stall}, 32'd0);
      tick();
      check("lu_cap_valid", {31'b0, ex_valid}, 32'd1);
      check("lu_cap_pc", ex_pc, 32'h204);
      check("lu_cap_rs1", ex_rs1_data, 32'hAA);
      check("lu_cap_rd", {27'b0, ex_rd}, 32'd6);

      // LUI x5 in EX: no hazard
      put(1, 32'h300, LUI_5, 32'd0, 32'd0);
      tick();
      check("lui_imm", ex_imm, 32'h12345000);
      check("lui_rd", {27'b0, ex_rd}, 32'd5);
      put(1, 32'h304, ADD_6_5_7, 32'hAA, 32'hBB);
      check("lui_stall", {31'b0, stall}, 32'd0);
      tick();
      check("lui_next_pc", ex_pc, 32'h304);

      // Load to x0 in EX: no hazard
      put(1, 32'h400, LW_0_1, 32'd0, 32'd0);
      tick();
      check("lwx0_rd", {27'b0, ex_rd}, 32'd0);
      put(1, 32'h404, ADD_6_0_7, 32'd0, 32'hBB);
      check("lwx0_stall", {31'b0, stall}, 32'd0);
      tick();
      check("lwx0_next_valid", {31'b0, ex_valid}, 32'd1);

      // Immediates
      put(1, 32'h500, SW_M4, 32'd1, 32'd2);
      tick();
      check("sw_imm", ex_imm, 32'hFFFFFFFC);
      check("sw_rd", {27'b0, ex_rd}, 32'd0);
      put(1, 32'h504, BEQ_M8, 32'd1, 32'd2);
      tick();
      check("beq_imm", ex_imm, 32'hFFFFFFF8);
      check("beq_rd", {27'b0, ex_rd}, 32'd0);
      put(1, 32'h508, JAL_2048, 32'd0, 32'd0);
      tick();
      check("jal_imm", ex_imm, 32'h00000800);
      check("jal_rd", {27'b0, ex_rd}, 32'd1);

      // Flush beats ex_stall
      put(1, 32'h600, ADD_3_1_2, 32'd1, 32'd2);
      ex_stall = 1; flush = 1;
      #1;
      check("fl_exs_stall", {31'b0, stall}, 32'd0);
      tick();
      check("fl_exs_valid", {31'b0, ex_valid}, 32'd0);
      ex_stall = 0; flush = 0;

      // Flush beats load-use
      put(1, 32'h610, LW_5_1, 32'd0, 32'd0);
      tick();
      put(1, 32'h614, ADD_6_5_7, 32'hAA, 32'hBB);
      flush = 1;
      #1;
      check("fl_lu_stall", {31'b0, stall}, 32'd0);
      tick();
      check("fl_lu_valid", {31'b0, ex_valid}, 32'd0);
      flush = 0;

      // ex_stall hold for three cycles with a WB write to x5 in the middle
      put(1, 32'h700, ADD_3_1_2, 32'h10, 32'h20);
      tick();
      put(1, 32'h704, ADD_6_5_7, 32'h30, 32'h40);
      ex_stall = 1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            wb_write_enable = 1; wb_addr_rd = 5'd5; wb_data_rd = 32'h99;
         end else begin
            wb_write_enable = 0; wb_addr_rd = 5'd0; wb_data_rd = 32'h0;
         end
         if (i == 2) data_rs1 = 32'h99;
         #1;
         check($sformatf("hold_stall_%0d", i), {31'b0, stall}, 32'd1);
         tick();
         check($sformatf("hold_pc_%0d", i), ex_pc, 32'h700);
         check($sformatf("hold_rs1_%0d", i), ex_rs1_data, 32'h10);
         check($sformatf("hold_valid_%0d", i), {31'b0, ex_valid}, 32'd1);
      end
      ex_stall = 0;
      #1;
      check("rel_stall", {31'b0, stall}, 32'd0);
      tick();
      check("rel_pc", ex_pc, 32'h704);
      check("rel_rs1", ex_rs1_data, 32'h99);
      check("rel_rs2", ex_rs2_data, 32'h40);

      // Reset while stalled
      ex_stall = 1;
      reset = 1;
      tick();
      reset = 0;
      ex_stall = 0;
      put(0, 32'h0, 32'h0, 32'h0, 32'h0);
      check("rst2_valid", {31'b0, ex_valid}, 32'd0);
      check("rst2_pc", ex_pc, 32'd0);
      check("rst2_rs1", ex_rs1_data, 32'd0);
      check("rst2_rd", {27'b0, ex_rd}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
